// File: rtl/inst_queue_pkg.sv
// Shared constants for the instruction queue and its downstream consumers.
package inst_queue_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 32;

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] NOP_INST  = 32'h0000_0013;
    localparam logic [INST_W-1:0] HALT_INST = 32'h0ff0_0513;

endpackage

// File: rtl/inst_queue.sv
// Circular FIFO of {instruction, PC} pairs between fetch and decode/issue.
// Occupancy is tracked explicitly, and a single-cycle clear flushes the queue.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned INST_W     = inst_queue_pkg::INST_W,
    parameter int unsigned ADDR_W     = inst_queue_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,
    input  logic                  inst_rdy,
    input  logic [INST_W-1:0]     inst_in,
    input  logic [ADDR_W-1:0]     pc_in,
    output logic                  iqueue_full,
    output logic                  out_valid,
    output logic [INST_W-1:0]     out_inst,
    output logic [ADDR_W-1:0]     out_pc,
    input  logic                  deq,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned              DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]      CNT_FULL  = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]      CNT_HIGH  = CNT_FULL - 1'b1;

    logic [INST_W-1:0]     inst_mem [DEPTH];
    logic [ADDR_W-1:0]     pc_mem   [DEPTH];

    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign out_valid   = (count_q != '0);
    assign iqueue_full = (count_q >= CNT_HIGH);
    assign count       = count_q;
    assign out_inst    = inst_mem[head_q];
    assign out_pc      = pc_mem[head_q];

    // A pop in the same cycle frees the slot, so push at full is legal then.
    assign do_pop  = rdy && !clear && deq && out_valid;
    assign do_push = rdy && !clear && inst_rdy && ((count_q != CNT_FULL) || do_pop);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy && clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop) begin
                head_d = head_q + 1'b1;
            end
            if (do_push) begin
                tail_d = tail_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            inst_mem[tail_q] <= inst_in;
            pc_mem[tail_q]   <= pc_in;
        end
    end

    // A compliant fetch stage never pushes into a full queue without a pop.
    push_while_full: assert property (@(posedge clk) disable iff (!rst)
        !(rdy && !clear && inst_rdy && (count_q == CNT_FULL) && !do_pop))
        else $error("inst_queue: push dropped while full");

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              clear;
    logic              inst_rdy;
    logic [31:0]       inst_in;
    logic [31:0]       pc_in;
    logic              iqueue_full;
    logic              out_valid;
    logic [31:0]       out_inst;
    logic [31:0]       out_pc;
    logic              deq;
    logic [4:0]        count;

    int tests_run = 0;
    int tests_failed = 0;

    inst_queue #(
        .DEPTH_LOG2 (4),
        .INST_W     (32),
        .ADDR_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clear       (clear),
        .inst_rdy    (inst_rdy),
        .inst_in     (inst_in),
        .pc_in       (pc_in),
        .iqueue_full (iqueue_full),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .deq         (deq),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
        inst_rdy = 1'b1;
        inst_in  = inst;
        pc_in    = pc;
        step();
        inst_rdy = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        rdy      = 1'b1;
        clear    = 1'b0;
        inst_rdy = 1'b0;
        deq      = 1'b0;
        inst_in  = '0;
        pc_in    = '0;
        step();
        check("reset_count", 64'(count), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_full", 64'(iqueue_full), 64'd0);
        rst = 1'b1;
        step();

        // Reset mid-operation
        for (int i = 0; i < 5; i++) push_one(32'h1000 + 32'(i), 32'h1000 + 32'(4 * i));
        check("t1_count5", 64'(count), 64'd5);
        #2;
        rst = 1'b0;
        #1;
        check("t1_async_count", 64'(count), 64'd0);
        check("t1_async_valid", 64'(out_valid), 64'd0);
        check("t1_async_full", 64'(iqueue_full), 64'd0);
        step();
        rst = 1'b1;
        step();
        inst_rdy = 1'b1;
        inst_in  = NOP_INST;
        pc_in    = 32'h0;
        #1;
        check("t1_no_bypass", 64'(out_valid), 64'd0);
        step();
        inst_rdy = 1'b0;
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_inst", 64'(out_inst), 64'h13);
        check("t1_pc", 64'(out_pc), 64'h0);
        deq = 1'b1;
        step();
        deq = 1'b0;
        check("t1_drained", 64'(count), 64'd0);

        // Fill to full
        for (int i = 0; i < 14; i++) push_one(32'h100 + 32'(i), 32'(4 * i));
        check("t2_count14", 64'(count), 64'd14);
        check("t2_not_full14", 64'(iqueue_full), 64'd0);
        push_one(32'h10e, 32'h38);
        check("t2_count15", 64'(count), 64'd15);
        check("t2_full15", 64'(iqueue_full), 64'd1);
        push_one(32'h10f, 32'h3c);
        check("t2_count16", 64'(count), 64'd16);
        check("t2_full16", 64'(iqueue_full), 64'd1);
        check("t2_head_pc", 64'(out_pc), 64'h0);

        // Simultaneous push and pop at full
        inst_rdy = 1'b1;
        deq      = 1'b1;
        inst_in  = 32'h110;
        pc_in    = 32'h40;
        step();
        inst_rdy = 1'b0;
        deq      = 1'b0;
        check("t4_count16", 64'(count), 64'd16);
        check("t4_head_pc", 64'(out_pc), 64'h4);
        check("t4_head_inst", 64'(out_inst), 64'h101);
        deq = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check("t4_drain_pc", 64'(out_pc), 64'(32'h4 + 32'(4 * i)));
            step();
        end
        deq = 1'b0;
        check("t4_count1", 64'(count), 64'd1);
        check("t4_new_pc", 64'(out_pc), 64'h40);
        check("t4_new_inst", 64'(out_inst), 64'h110);
        deq = 1'b1;
        step();
        deq = 1'b0;
        check("t4_empty", 64'(out_valid), 64'd0);

        // Ordering and wrap-around with steady push+pop
        push_one(32'h2000, 32'h100);
        inst_rdy = 1'b1;
        deq      = 1'b1;
        for (int i = 0; i < 40; i++) begin
            inst_in = 32'h2001 + 32'(i);
            pc_in   = 32'h104 + 32'(4 * i);
            #1;
            check("t3_pc", 64'(out_pc), 64'(32'h100 + 32'(4 * i)));
            check("t3_inst", 64'(out_inst), 64'(32'h2000 + 32'(i)));
            step();
            check("t3_count", 64'(count), 64'd1);
        end
        inst_rdy = 1'b0;
        deq      = 1'b0;
        check("t3_final_pc", 64'(out_pc), 64'h1a0);

        // Clear with coincident push and pop
        for (int i = 0; i < 6; i++) push_one(32'h3000 + 32'(i), 32'h1a4 + 32'(4 * i));
        check("t5_count7", 64'(count), 64'd7);
        clear    = 1'b1;
        inst_rdy = 1'b1;
        deq      = 1'b1;
        inst_in  = 32'h3fff;
        pc_in    = 32'h1bc;
        step();
        clear    = 1'b0;
        inst_rdy = 1'b0;
        deq      = 1'b0;
        check("t5_count0", 64'(count), 64'd0);
        check("t5_valid0", 64'(out_valid), 64'd0);
        push_one(HALT_INST, 32'h200);
        check("t5_count1", 64'(count), 64'd1);
        check("t5_head_pc", 64'(out_pc), 64'h200);
        check("t5_head_inst", 64'(out_inst), 64'(HALT_INST));

        // rdy gating
        push_one(32'h4001, 32'h204);
        push_one(32'h4002, 32'h208);
        rdy      = 1'b0;
        inst_rdy = 1'b1;
        deq      = 1'b1;
        inst_in  = 32'h4003;
        pc_in    = 32'h20c;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_hold_count", 64'(count), 64'd3);
            check("t6_hold_pc", 64'(out_pc), 64'h200);
            check("t6_hold_full", 64'(iqueue_full), 64'd0);
        end
        rdy = 1'b1;
        step();
        inst_rdy = 1'b0;
        check("t6_resume_count", 64'(count), 64'd3);
        check("t6_resume_pc", 64'(out_pc), 64'h204);
        step();
        deq = 1'b0;
        check("t6_pop_count", 64'(count), 64'd2);
        check("t6_pop_pc", 64'(out_pc), 64'h208);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular FIFO of fetched instructions, paired with their PCs.
- Sits directly downstream of the fetch stage and upstream of decode/issue.
- Absorbs fetch bursts and decouples fetch from issue stalls.
- Supports a single-cycle flush on branch redirect or misprediction recovery.

Parameters:
- DEPTH_LOG2, 4, log2 of entry count (DEPTH = 16).
- INST_W, 32, instruction width.
- ADDR_W, 32, PC width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global enable; when low, all state holds.
- clear  input  1  synchronous flush from the commit/branch unit.
- inst_rdy  input  1  push strobe from fetch.
- inst_in  input  INST_W  instruction to push.
- pc_in  input  ADDR_W  PC of the pushed instruction.
- iqueue_full  output  1  back-pressure to fetch.
- out_valid  output  1  head entry present.
- out_inst  output  INST_W  head instruction.
- out_pc  output  ADDR_W  head PC.
- deq  input  1  consumer pops the head this cycle.
- count  output  DEPTH_LOG2+1  current occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - head = 0, tail = 0, count = 0.
  - out_valid = 0, iqueue_full = 0.
  - Storage contents are don't-care.
- rdy low: no push, no pop, no clear. Pointers and count hold. Outputs remain a function of the held state.
- Push:
  - Occurs when inst_rdy && count != DEPTH.
  - Writes {inst_in, pc_in} at tail; tail += 1 mod DEPTH.
  - A push while count == DEPTH is dropped. This is unreachable under correct back-pressure and gets a simulation assertion.
- Pop:
  - Occurs when deq && out_valid; head += 1 mod DEPTH.
  - deq while empty is ignored.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal even when count == DEPTH (the pop frees the slot first).
- Outputs:
  - out_valid = (count != 0), combinational.
  - out_inst and out_pc are read combinationally at head.
  - Push-to-visible latency is 1 cycle: an entry pushed at edge N is visible after edge N. There is no bypass of an empty queue.
- Full threshold:
  - iqueue_full = (count >= DEPTH-1), combinational from registered count.
  - Fetch registers its push one cycle after sampling full, so one push can be in flight. The threshold leaves one slack slot; overflow cannot occur with a compliant fetch stage.
- Clear:
  - Highest priority. On a clear edge: head = tail = count = 0.
  - A coincident push and a coincident pop are both discarded.
  - out_valid is 0 from the next cycle.
- Wrap-around:
  - Pointers are DEPTH_LOG2 bits and wrap naturally.
  - count is kept explicitly; full and empty are never inferred from pointer equality.
- Storage:
  - Plain register array, no reset required.
  - Write port on tail, read port on head.

Decomposition:
- Shared package holds:
  - INST_W and ADDR_W.
  - The NOP encoding (32'h00000013) used by downstream stages.
  - The halt encoding 32'h0ff00513 as a named constant.
- No sub-module is needed; storage, pointers and count stay in one module.
- Optional: factor the array into iq_ram (1W1R, asynchronous read) if the team wants reuse for the load/store buffer.

Test Plan:
1. Reset mid-operation:
   - Push 5 entries, then drop rst low between edges.
   - Required: immediately count = 0, out_valid = 0, iqueue_full = 0.
   - After release, the first push of {0x00000013, 0x0} appears at out_* one cycle later.
2. Fill to full:
   - Push 15 entries with PCs 0x0, 0x4, ..., 0x38 and no deq.
   - Required: iqueue_full = 1 when count = 15.
   - One further in-flight push (PC 0x3C) is accepted, giving count = 16.
   - A 17th push is dropped and the assertion fires.
3. Ordering and wrap-around:
   - Push and pop continuously for 40 cycles, PC incrementing by 4 from 0x100.
   - Required: out_pc sequence is 0x100, 0x104, ... with no gaps through pointer wrap; count stays constant.
4. Simultaneous push and pop at full:
   - At count = 16, assert inst_rdy and deq together.
   - Required: count stays 16; the head advances; the new entry lands at the vacated slot.
5. Clear with coincident push and pop:
   - At count = 7, assert clear, inst_rdy and deq in the same cycle.
   - Required: count = 0 and out_valid = 0 next cycle.
   - The next push (PC 0x200) is the new head.
6. rdy gating:
   - Hold rdy low for 3 cycles while inst_rdy and deq are high.
   - Required: count, out_pc and iqueue_full are unchanged throughout; operation resumes normally when rdy returns high.
